// File: rtl/load_store_sequencer_pkg.sv
// Shared constants for the load/store sequencer: access-size encodings,
// FSM state encodings and a helper giving the index of the last byte lane.
package load_store_sequencer_pkg;

  // Access size encodings on i_size (2'b11 behaves as a word)
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Sequencer FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCESS = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  // Index of the final byte of an access: 0 for byte, 1 for half, 3 for word
  function automatic logic [1:0] lastByteIdx(input logic [1:0] size);
    logic [1:0] idx;
    case (size)
      SIZE_BYTE: idx = 2'd0;
      SIZE_HALF: idx = 2'd1;
      default:   idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/load_store_sequencer_load_extender.sv
// load_extender: combinational sign/zero extension of an assembled load word.
// Kept standalone so other load paths can reuse it.
module load_extender
  import load_store_sequencer_pkg::*;
#(
  parameter int WORD_LEN      = 32,
  parameter int MEM_CELL_SIZE = 8
) (
  input  logic [WORD_LEN-1:0] i_raw,
  input  logic [1:0]          i_size,
  input  logic                i_unsigned,
  output logic [WORD_LEN-1:0] o_ext
);

  logic w_byteFill;
  logic w_halfFill;

  // Pick the fill bit from the top of the loaded width and replicate it upward
  always_comb begin
    w_byteFill = ~i_unsigned & i_raw[MEM_CELL_SIZE-1];
    w_halfFill = ~i_unsigned & i_raw[2*MEM_CELL_SIZE-1];
    o_ext      = i_raw;
    case (i_size)
      SIZE_BYTE: o_ext = {{(WORD_LEN-MEM_CELL_SIZE){w_byteFill}}, i_raw[MEM_CELL_SIZE-1:0]};
      SIZE_HALF: o_ext = {{(WORD_LEN-2*MEM_CELL_SIZE){w_halfFill}}, i_raw[2*MEM_CELL_SIZE-1:0]};
      default:   o_ext = i_raw;
    endcase
  end

endmodule

// File: rtl/load_store_sequencer.sv
// load_store_sequencer: MEM-stage initiator that splits pipeline loads/stores
// into little-endian byte accesses on an 8-bit synchronous memory port and
// assembles/extends load data. Four byte lanes per word are assumed.
// Optional build macro ALIGN_CHECK_EN: rejects misaligned half/word requests
// through an error state instead of issuing byte accesses.
module load_store_sequencer
  import load_store_sequencer_pkg::*;
#(
  parameter int WORD_LEN      = 32,
  parameter int MEM_CELL_SIZE = 8,
  parameter int MEM_ADDR_LEN  = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_write,
  input  logic [1:0]               i_size,
  input  logic                     i_unsigned,
  input  logic [WORD_LEN-1:0]      i_addr,
  input  logic [WORD_LEN-1:0]      i_wdata,
  output logic [WORD_LEN-1:0]      o_rdata,
  output logic                     o_done,
  output logic                     o_busy,
  output logic                     o_misaligned,
  output logic                     o_mem_en,
  output logic                     o_mem_we,
  output logic [MEM_ADDR_LEN-1:0]  o_mem_addr,
  output logic [MEM_CELL_SIZE-1:0] o_mem_wdata,
  input  logic [MEM_CELL_SIZE-1:0] i_mem_rdata
);

  logic [2:0]               r_state;
  logic                     r_write;
  logic                     r_unsigned;
  logic [1:0]               r_size;
  logic [WORD_LEN-1:0]      r_wdata;
  logic [1:0]               r_lastIdx;
  logic [1:0]               r_idx;
  logic                     r_memEn;
  logic                     r_memWe;
  logic [MEM_ADDR_LEN-1:0]  r_memAddr;
  logic [MEM_CELL_SIZE-1:0] r_memWdata;
  logic [WORD_LEN-1:0]      r_buf;
  logic                     r_capValid;
  logic [1:0]               r_capIdx;
  logic [WORD_LEN-1:0]      r_rdata;

  logic                     w_accept;
  logic                     w_misaligned;
  logic [1:0]               w_nextIdx;
  logic [WORD_LEN-1:0]      w_merged;
  logic [WORD_LEN-1:0]      w_ext;
  logic                     w_unused;

  assign w_accept  = i_req_valid & (r_state == ST_IDLE);
  assign w_nextIdx = r_idx + 2'd1;
  assign w_unused  = ^i_addr[WORD_LEN-1:MEM_ADDR_LEN];

`ifdef ALIGN_CHECK_EN
  // Half needs addr[0]==0, word (and the 11 alias) needs addr[1:0]==0
  always_comb begin
    w_misaligned = 1'b0;
    if (i_size == SIZE_HALF)
      w_misaligned = i_addr[0];
    else if (i_size != SIZE_BYTE)
      w_misaligned = |i_addr[1:0];
  end
  assign o_misaligned = (r_state == ST_ERR);
`else
  assign w_misaligned = 1'b0;
  assign o_misaligned = 1'b0;
`endif

  // Main FSM plus the registered memory-port strobes for the next byte
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_wdata    <= '0;
      r_lastIdx  <= 2'd0;
      r_idx      <= 2'd0;
      r_memEn    <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_write    <= i_write;
            r_unsigned <= i_unsigned;
            r_size     <= i_size;
            r_wdata    <= i_wdata;
            r_lastIdx  <= lastByteIdx(i_size);
            r_idx      <= 2'd0;
            if (w_misaligned) begin
              r_state <= ST_ERR;
            end else begin
              r_state    <= ST_ACCESS;
              r_memEn    <= 1'b1;
              r_memWe    <= i_write;
              r_memAddr  <= i_addr[MEM_ADDR_LEN-1:0];
              r_memWdata <= i_write ? i_wdata[MEM_CELL_SIZE-1:0] : '0;
            end
          end
        end
        ST_ACCESS: begin
          if (r_idx == r_lastIdx) begin
            r_memEn <= 1'b0;
            r_memWe <= 1'b0;
            r_state <= r_write ? ST_DONE : ST_DRAIN;
          end else begin
            r_idx      <= w_nextIdx;
            r_memAddr  <= r_memAddr + MEM_ADDR_LEN'(1);
            r_memWdata <= r_write ? r_wdata[MEM_CELL_SIZE*w_nextIdx +: MEM_CELL_SIZE] : '0;
          end
        end
        ST_DRAIN: r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        ST_ERR:   r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Read data arrives one cycle after its strobe; merge it into its byte lane
  always_comb begin
    w_merged = r_buf;
    w_merged[MEM_CELL_SIZE*r_capIdx +: MEM_CELL_SIZE] = i_mem_rdata;
  end

  // Track which lane returns next and accumulate the assembled load word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_capValid <= 1'b0;
      r_capIdx   <= 2'd0;
      r_buf      <= '0;
    end else begin
      r_capValid <= (r_state == ST_ACCESS) & ~r_write;
      r_capIdx   <= r_idx;
      if (w_accept)
        r_buf <= '0;
      else if (r_capValid)
        r_buf <= w_merged;
    end
  end

  load_extender #(
    .WORD_LEN      (WORD_LEN),
    .MEM_CELL_SIZE (MEM_CELL_SIZE)
  ) u_extender (
    .i_raw      (w_merged),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_ext      (w_ext)
  );

  // The final lane lands during DRAIN, so the extended result is taken then
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_rdata <= '0;
    else if (r_state == ST_DRAIN)
      r_rdata <= w_ext;
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE) | (r_state == ST_ERR);
  assign o_rdata     = r_rdata;
  assign o_mem_en    = r_memEn;
  assign o_mem_we    = r_memWe;
  assign o_mem_addr  = r_memAddr;
  assign o_mem_wdata = r_memWdata;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Testbench for load_store_sequencer: byte-array memory model, scoreboard
// queues of expected strobes and completions, directed cases then random ops.
// Honours ALIGN_CHECK_EN when compiled with it.
module tb_load_store_sequencer;

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [7:0] data;
  } strobe_t;

  typedef struct {
    int          cycle;
    logic [31:0] rdata;
    logic        mis;
  } resp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        isUnsigned = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        misaligned;
  logic        memEn;
  logic        memWe;
  logic [9:0]  memAddr;
  logic [7:0]  memWdata;
  logic [7:0]  memRdata = '0;

  int vectors = 0;
  int miscompares = 0;
  int cycleCnt = 0;

  logic [7:0]  memArr [1024];
  logic [7:0]  refMem [1024];
  logic [31:0] lastRdata = '0;

  strobe_t strobeQ[$];
  resp_t   respQ[$];
  strobe_t monS;
  resp_t   monR;

  load_store_sequencer dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_req_valid  (reqValid),
    .o_req_ready  (reqReady),
    .i_write      (write),
    .i_size       (size),
    .i_unsigned   (isUnsigned),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_rdata      (rdata),
    .o_done       (done),
    .o_busy       (busy),
    .o_misaligned (misaligned),
    .o_mem_en     (memEn),
    .o_mem_we     (memWe),
    .o_mem_addr   (memAddr),
    .o_mem_wdata  (memWdata),
    .i_mem_rdata  (memRdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Synchronous 1-cycle-read byte memory
  always @(posedge clk) begin
    if (memEn) begin
      if (memWe) memArr[memAddr] <= memWdata;
      else       memRdata <= memArr[memAddr];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cycleCnt);
    end
  endtask

  task automatic reportFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: unexpected event at cycle %0d", name, cycleCnt);
  endtask

  // Monitor: pops expectations whenever the DUT strobes memory or completes
  always @(negedge clk) begin
    if (rstN) begin
      if (memEn) begin
        if (strobeQ.size() == 0) reportFail("unexpectedStrobe");
        else begin
          monS = strobeQ.pop_front();
          checkOutput("strobeWe", 64'(memWe), 64'(monS.we));
          checkOutput("strobeAddr", 64'(memAddr), 64'(monS.addr));
          if (monS.we) checkOutput("strobeData", 64'(memWdata), 64'(monS.data));
        end
      end
      if (done) begin
        if (respQ.size() == 0) reportFail("unexpectedDone");
        else begin
          monR = respQ.pop_front();
          checkOutput("doneCycle", 64'(cycleCnt), 64'(monR.cycle));
          checkOutput("rdata", 64'(rdata), 64'(monR.rdata));
          checkOutput("misaligned", 64'(misaligned), 64'(monR.mis));
          checkOutput("busyAtDone", 64'(busy), 64'd1);
        end
      end else if (misaligned) begin
        reportFail("strayMisaligned");
      end
    end
  end

  task automatic checkResetOutputs();
    checkOutput("rstRdata", 64'(rdata), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstMis", 64'(misaligned), 64'd0);
    checkOutput("rstMemEn", 64'(memEn), 64'd0);
    checkOutput("rstMemWe", 64'(memWe), 64'd0);
    checkOutput("rstMemAddr", 64'(memAddr), 64'd0);
    checkOutput("rstMemWdata", 64'(memWdata), 64'd0);
    checkOutput("rstReady", 64'(reqReady), 64'd1);
  endtask

  task automatic waitReady(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!reqReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = reqReady;
    if (!ok) reportFail("readyTimeout");
  endtask

  // Issue one request; the reference model pushes expected strobes and completion
  task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                               input logic [31:0] ad, input logic [31:0] wd,
                               input bit useOvr, input logic [31:0] ovr);
    bit ok;
    int n;
    int t;
    bit mis;
    logic [9:0]  a;
    logic [9:0]  ak;
    logic [63:0] raw;
    logic [31:0] ext;
    strobe_t s;
    resp_t r;
    waitReady(ok);
    if (!ok) return;
    reqValid = 1'b1; write = wr; size = sz; isUnsigned = uns; addr = ad; wdata = wd;
    t = cycleCnt;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    a = ad[9:0];
    mis = 1'b0;
`ifdef ALIGN_CHECK_EN
    mis = (n == 2 && ad[0]) || (n == 4 && ad[1:0] != 2'b00);
`endif
    if (mis) begin
      r.cycle = t + 1; r.rdata = lastRdata; r.mis = 1'b1;
    end else if (wr) begin
      for (int k = 0; k < n; k++) begin
        ak = a + 10'(k);
        refMem[ak] = wd[8*k +: 8];
        s.we = 1'b1; s.addr = ak; s.data = wd[8*k +: 8];
        strobeQ.push_back(s);
      end
      r.cycle = t + n + 1; r.rdata = lastRdata; r.mis = 1'b0;
    end else begin
      raw = '0;
      for (int k = 0; k < n; k++) begin
        ak = a + 10'(k);
        raw = raw | (64'(refMem[ak]) << (8*k));
        s.we = 1'b0; s.addr = ak; s.data = 8'h00;
        strobeQ.push_back(s);
      end
      if (n == 4) ext = raw[31:0];
      else if (!uns && raw[8*n-1]) ext = 32'(raw - (64'd1 << (8*n)));
      else ext = raw[31:0];
      lastRdata = useOvr ? ovr : ext;
      r.cycle = t + n + 2; r.rdata = lastRdata; r.mis = 1'b0;
    end
    respQ.push_back(r);
    // A request seen while busy must be ignored
    @(negedge clk);
    reqValid = 1'b1; write = $urandom_range(0, 1); size = 2'($urandom_range(0, 3));
    addr = $urandom; wdata = $urandom;
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  // Word store to 0x40 aborted by reset in its second access cycle
  task automatic resetMidStore();
    bit ok;
    strobe_t s;
    waitReady(ok);
    if (!ok) return;
    reqValid = 1'b1; write = 1'b1; size = 2'b10; isUnsigned = 1'b0;
    addr = 32'h40; wdata = 32'hCAFEF00D;
    refMem[10'h40] = 8'h0D;
    s.we = 1'b1; s.addr = 10'h40; s.data = 8'h0D;
    strobeQ.push_back(s);
    @(negedge clk);
    reqValid = 1'b0;
    @(posedge clk);
    #1 rstN = 1'b0;
    lastRdata = '0;
    #2 checkResetOutputs();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    bit wr;
    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      memArr[i] = b;
      refMem[i] = b;
    end
    repeat (3) @(negedge clk);
    checkResetOutputs();
    rstN = 1'b1;

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h20, 32'h00000080, 1'b0, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b1, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 1'b1, 32'h00000080);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h30, 32'h00009234, 1'b0, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 1'b1, 32'hFFFF9234);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 1'b1, 32'h00009234);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h3FF, 32'h11223344, 1'b0, 32'h0);
    resetMidStore();
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < 150; i++) begin
      wr = 1'($urandom_range(0, 1));
      applyStimulus(wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, 1'b0, 32'h0);
    end

    repeat (12) @(negedge clk);
    checkOutput("strobeQueueDrained", 64'(strobeQ.size()), 64'd0);
    checkOutput("respQueueDrained", 64'(respQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
